prince_ti_round_ctrl: RTL and testbench
=======================================

Name: prince_ti_round_ctrl

Overview:
- Sequencing controller for the 2-share PRINCE threshold-implementation core.
- Drives the state-register enables, the S-box direction select, the linear-layer select (M / M' / M^-1), the round-constant index and the fresh-randomness request for the shared datapath (affine, S-box and linear layers on both shares).
- Sits between the core's start/done handshake and the share datapath.
- Holds no data; it produces control signals only.

Parameters:
SBOX_LAT, 2, register stages in the shared S-box pipeline (>=1)
RC_W, 4, width of the round-constant index

Ports:
i_clk  input  1  clock
i_rst  input  1  synchronous reset, active-high
i_start  input  1  start request; accepted only when o_ready=1
i_abort  input  1  abandon the current encryption
o_ready  output  1  idle and able to accept i_start
o_busy  output  1  encryption in progress
o_ld_en  output  1  load input shares with whitening (k0, k1, RC0) into the state register
o_st_en  output  1  state-register write enable
o_sb_en  output  1  advance the S-box pipeline
o_sb_inv  output  1  0 = S, 1 = S^-1
o_lin_sel  output  2  0 = M, 1 = M', 2 = M^-1, 3 = bypass
o_rc_en  output  1  XOR the round constant and k1 into the state
o_rc_idx  output  RC_W  round-constant index, 0..11
o_fresh_en  output  1  request fresh mask randomness this cycle
o_done  output  1  one-cycle pulse: result valid on the state register

Behaviour:
- Reset values:
  - o_ready=1.
  - All other outputs 0; o_lin_sel=3, o_rc_idx=0.
  - FSM in IDLE; counters cleared.
- Reset mid-operation returns to IDLE on the next edge. No o_done is produced.
- States: IDLE, INIT, SB, LIN, MSB, MLIN, MISB, BLIN, BSB, FIN, DONE.
- IDLE: o_ready=1. On i_start, go to INIT with rnd=1 and sb_cnt=0. i_start while not in IDLE is ignored.
- INIT (1 cycle): o_ld_en=1, o_st_en=1, o_rc_en=1, o_rc_idx=0. Next state SB.
- SB (forward rounds rnd=1..5), SBOX_LAT cycles:
  - o_sb_en=1, o_fresh_en=1, o_sb_inv=0.
  - o_st_en=1 only when sb_cnt==SBOX_LAT-1; that cycle moves to LIN.
- LIN (1 cycle): o_lin_sel=0, o_rc_en=1, o_rc_idx=rnd, o_st_en=1.
  - If rnd==5: go to MSB.
  - Else: rnd+1, go to SB.
- MSB: same as SB with o_sb_inv=0. Exits to MLIN.
- MLIN (1 cycle): o_lin_sel=1, o_rc_en=0, o_rc_idx=0, o_st_en=1. Exits to MISB.
- MISB: same as SB with o_sb_inv=1. Exits to BLIN with rnd=6.
- BLIN (1 cycle): o_lin_sel=2, o_rc_en=1, o_rc_idx=rnd, o_st_en=1. Exits to BSB.
- BSB: SB timing with o_sb_inv=1.
  - If rnd==10: go to FIN.
  - Else: rnd+1, go to BLIN.
- FIN (1 cycle): o_lin_sel=3, o_rc_en=1, o_rc_idx=11, o_st_en=1. Next state DONE.
- DONE (1 cycle): o_done=1, o_busy=0. Next state IDLE.
- o_busy=1 in every state except IDLE and DONE.
- o_fresh_en=1 in all S-box cycles only.
- Outside SB/MSB/MISB/BSB: o_sb_en=0 and o_sb_inv=0.
- Latency: i_start accepted at edge t0 gives o_done high at cycle t0+12*SBOX_LAT+14 (38 cycles for SBOX_LAT=2).
  - INIT occupies t0+1; FIN occupies t0+12*SBOX_LAT+13.
- Back-to-back: o_ready returns the cycle after DONE; i_start is accepted there.
- i_abort in any busy state: go to IDLE next edge; no o_done; all enables 0 next cycle. i_abort in IDLE/DONE has no effect; DONE still pulses.
- i_abort and i_start in the same IDLE cycle: start is accepted, because abort is ignored in IDLE.
- Counters: rnd is 4 bits and never exceeds 10. sb_cnt is clog2(SBOX_LAT+1) bits and wraps to 0 on each S-box phase exit.

Decomposition:
- prince_ti_pkg holds:
  - state enum
  - LIN_M/LIN_MP/LIN_MINV/LIN_BYP constants
  - NUM_RC=12, FWD_ROUNDS=5, RC_FIN=11
- One sub-module: prince_ti_lat_cnt, a load/clear/terminal-count counter for SBOX_LAT, reused by all S-box phases.
- The output decode stays in the FSM.

Test Plan:
- Reset, then i_start at t0 (SBOX_LAT=2) -> o_ld_en at t0+1; o_done single pulse at t0+38; o_busy high t0+1..t0+37.
- Same run, log o_rc_idx whenever o_rc_en=1 -> sequence 0,1,2,3,4,5,6,7,8,9,10,11. o_lin_sel sequence over LIN/MLIN/BLIN cycles -> 0x5, 1, 2x5. o_sb_inv=1 exactly in 2*6=12 S-box cycles.
- Count o_fresh_en and o_st_en cycles per run -> 24 and 25 respectively.
- Assert i_abort at t0+20 -> IDLE at t0+21, o_ready=1, no o_done. A new i_start at t0+22 completes normally with o_done at t0+60.
- Pulse i_start at t0+10 during a run -> ignored; o_done only at t0+38. i_start at t0+39 (first o_ready cycle) -> o_done at t0+77.
- Assert i_rst at t0+15 -> next cycle all outputs at reset values. SBOX_LAT=1 build -> o_done at t0+26.

Source files
------------

// File: rtl/prince_ti_pkg.sv
// rtl/prince_ti_pkg.sv - shared types and constants for the PRINCE TI round controller
// Purpose: FSM state encoding, linear-layer select codes and round bookkeeping
//          constants used by prince_ti_round_ctrl and its latency counter.
// Ports:   none (package).
package prince_ti_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INIT,
    ST_SB,
    ST_LIN,
    ST_MSB,
    ST_MLIN,
    ST_MISB,
    ST_BLIN,
    ST_BSB,
    ST_FIN,
    ST_DONE
  } state_e;

  localparam logic [1:0] LIN_M    = 2'd0;
  localparam logic [1:0] LIN_MP   = 2'd1;
  localparam logic [1:0] LIN_MINV = 2'd2;
  localparam logic [1:0] LIN_BYP  = 2'd3;

  localparam int NUM_RC     = 12;
  localparam int FWD_ROUNDS = 5;
  localparam int RC_FIN     = 11;
  // Last backward round index; RC_FIN belongs to the final whitening step.
  localparam int BWD_LAST   = NUM_RC - 2;

  function automatic logic is_sbox(input state_e s);
    return (s == ST_SB) || (s == ST_MSB) || (s == ST_MISB) || (s == ST_BSB);
  endfunction

endpackage

// File: rtl/prince_ti_lat_cnt.sv
// rtl/prince_ti_lat_cnt.sv - S-box pipeline latency counter with terminal count
// Purpose: counts the cycles of one S-box phase; wraps to 0 after LAT cycles.
// Ports:   i_clk, i_rst (sync, active-high), i_clr (force to 0), i_adv (count),
//          o_tc (current count is the last one), o_tc_nxt (next count is the last one).
module prince_ti_lat_cnt #(
  parameter int LAT = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_adv,
  output logic o_tc,
  output logic o_tc_nxt
);

  localparam int W = $clog2(LAT + 1);
  localparam logic [W-1:0] LAST = W'(LAT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_adv) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign o_tc     = (cnt_q == LAST);
  // The controller registers its outputs, so it needs to know whether the
  // cycle it is about to enter is the last S-box cycle.
  assign o_tc_nxt = (cnt_d == LAST);

endmodule

// File: rtl/prince_ti_round_ctrl.sv
// rtl/prince_ti_round_ctrl.sv - sequencing FSM for the 2-share PRINCE TI core
// Purpose: walks INIT, 5 forward rounds, the middle S/M'/S^-1 layer, 5 backward
//          rounds and the final whitening, emitting registered datapath controls.
// Ports:   i_clk, i_rst (sync, active-high), i_start, i_abort;
//          o_ready, o_busy, o_done handshake; o_ld_en, o_st_en, o_sb_en, o_sb_inv,
//          o_lin_sel, o_rc_en, o_rc_idx, o_fresh_en datapath controls.
module prince_ti_round_ctrl
  import prince_ti_pkg::*;
#(
  parameter int SBOX_LAT = 2,
  parameter int RC_W     = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic            i_abort,
  output logic            o_ready,
  output logic            o_busy,
  output logic            o_ld_en,
  output logic            o_st_en,
  output logic            o_sb_en,
  output logic            o_sb_inv,
  output logic [1:0]      o_lin_sel,
  output logic            o_rc_en,
  output logic [RC_W-1:0] o_rc_idx,
  output logic            o_fresh_en,
  output logic            o_done
);

  state_e     state_q, state_d;
  logic [3:0] rnd_q, rnd_d;
  logic       in_sb, sb_tc, sb_tc_nxt, abort_now;

  logic            ready_d, busy_d, ld_en_d, st_en_d, sb_en_d, sb_inv_d;
  logic            rc_en_d, fresh_en_d, done_d;
  logic [1:0]      lin_sel_d;
  logic [RC_W-1:0] rc_idx_d;

  assign in_sb     = is_sbox(state_q);
  // Abort only matters while a run is in flight; DONE always completes.
  assign abort_now = i_abort && (state_q != ST_IDLE) && (state_q != ST_DONE);

  prince_ti_lat_cnt #(
    .LAT(SBOX_LAT)
  ) u_lat_cnt (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (!in_sb || abort_now),
    .i_adv   (in_sb),
    .o_tc    (sb_tc),
    .o_tc_nxt(sb_tc_nxt)
  );

  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    if (abort_now) begin
      state_d = ST_IDLE;
      rnd_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: if (i_start) begin
          state_d = ST_INIT;
          rnd_d   = 4'd1;
        end
        ST_INIT: state_d = ST_SB;
        ST_SB:   if (sb_tc) state_d = ST_LIN;
        ST_LIN: begin
          if (rnd_q == 4'(FWD_ROUNDS)) begin
            state_d = ST_MSB;
          end else begin
            rnd_d   = rnd_q + 4'd1;
            state_d = ST_SB;
          end
        end
        ST_MSB:  if (sb_tc) state_d = ST_MLIN;
        ST_MLIN: state_d = ST_MISB;
        ST_MISB: if (sb_tc) begin
          state_d = ST_BLIN;
          rnd_d   = 4'(FWD_ROUNDS + 1);
        end
        ST_BLIN: state_d = ST_BSB;
        ST_BSB:  if (sb_tc) begin
          if (rnd_q == 4'(BWD_LAST)) begin
            state_d = ST_FIN;
          end else begin
            rnd_d   = rnd_q + 4'd1;
            state_d = ST_BLIN;
          end
        end
        ST_FIN:  state_d = ST_DONE;
        ST_DONE: begin
          state_d = ST_IDLE;
          rnd_d   = '0;
        end
        default: begin
          state_d = ST_IDLE;
          rnd_d   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the state being entered and then registered,
  // so they line up with the cycle that state occupies.
  always_comb begin
    ready_d    = 1'b0;
    busy_d     = 1'b1;
    ld_en_d    = 1'b0;
    st_en_d    = 1'b0;
    sb_en_d    = 1'b0;
    sb_inv_d   = 1'b0;
    rc_en_d    = 1'b0;
    fresh_en_d = 1'b0;
    done_d     = 1'b0;
    lin_sel_d  = LIN_BYP;
    rc_idx_d   = '0;
    case (state_d)
      ST_IDLE: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
      ST_INIT: begin
        ld_en_d = 1'b1;
        st_en_d = 1'b1;
        rc_en_d = 1'b1;
      end
      ST_SB, ST_MSB: begin
        sb_en_d    = 1'b1;
        fresh_en_d = 1'b1;
        st_en_d    = sb_tc_nxt;
      end
      ST_MISB, ST_BSB: begin
        sb_en_d    = 1'b1;
        sb_inv_d   = 1'b1;
        fresh_en_d = 1'b1;
        st_en_d    = sb_tc_nxt;
      end
      ST_LIN: begin
        lin_sel_d = LIN_M;
        rc_en_d   = 1'b1;
        rc_idx_d  = RC_W'(rnd_d);
        st_en_d   = 1'b1;
      end
      ST_MLIN: begin
        lin_sel_d = LIN_MP;
        st_en_d   = 1'b1;
      end
      ST_BLIN: begin
        lin_sel_d = LIN_MINV;
        rc_en_d   = 1'b1;
        rc_idx_d  = RC_W'(rnd_d);
        st_en_d   = 1'b1;
      end
      ST_FIN: begin
        rc_en_d  = 1'b1;
        rc_idx_d = RC_W'(RC_FIN);
        st_en_d  = 1'b1;
      end
      ST_DONE: begin
        done_d = 1'b1;
        busy_d = 1'b0;
      end
      default: busy_d = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      rnd_q      <= '0;
      o_ready    <= 1'b1;
      o_busy     <= 1'b0;
      o_ld_en    <= 1'b0;
      o_st_en    <= 1'b0;
      o_sb_en    <= 1'b0;
      o_sb_inv   <= 1'b0;
      o_lin_sel  <= LIN_BYP;
      o_rc_en    <= 1'b0;
      o_rc_idx   <= '0;
      o_fresh_en <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rnd_q      <= rnd_d;
      o_ready    <= ready_d;
      o_busy     <= busy_d;
      o_ld_en    <= ld_en_d;
      o_st_en    <= st_en_d;
      o_sb_en    <= sb_en_d;
      o_sb_inv   <= sb_inv_d;
      o_lin_sel  <= lin_sel_d;
      o_rc_en    <= rc_en_d;
      o_rc_idx   <= rc_idx_d;
      o_fresh_en <= fresh_en_d;
      o_done     <= done_d;
    end
  end

endmodule

// File: tb/tb_prince_ti_round_ctrl.sv
// tb/tb_prince_ti_round_ctrl.sv - directed self-checking bench for prince_ti_round_ctrl
module tb_prince_ti_round_ctrl;

  logic clk = 1'b0;
  logic i_rst, i_start, i_abort;

  logic       r0, b0, ld0, st0, sbe0, inv0, rce0, fr0, dn0;
  logic [1:0] ls0;
  logic [3:0] ri0;
  logic       r1, b1, ld1, st1, sbe1, inv1, rce1, fr1, dn1;
  logic [1:0] ls1;
  logic [3:0] ri1;

  always #5 clk = ~clk;

  prince_ti_round_ctrl #(.SBOX_LAT(2), .RC_W(4)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_abort(i_abort),
    .o_ready(r0), .o_busy(b0), .o_ld_en(ld0), .o_st_en(st0), .o_sb_en(sbe0),
    .o_sb_inv(inv0), .o_lin_sel(ls0), .o_rc_en(rce0), .o_rc_idx(ri0),
    .o_fresh_en(fr0), .o_done(dn0)
  );

  prince_ti_round_ctrl #(.SBOX_LAT(1), .RC_W(4)) dut_lat1 (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_abort(i_abort),
    .o_ready(r1), .o_busy(b1), .o_ld_en(ld1), .o_st_en(st1), .o_sb_en(sbe1),
    .o_sb_inv(inv1), .o_lin_sel(ls1), .o_rc_en(rce1), .o_rc_idx(ri1),
    .o_fresh_en(fr1), .o_done(dn1)
  );

  // {ready, busy, ld, st, sb_en, sb_inv, lin_sel[1:0], rc_en, rc_idx[3:0], fresh, done}
  wire [14:0] v0 = {r0, b0, ld0, st0, sbe0, inv0, ls0, rce0, ri0, fr0, dn0};
  wire [14:0] v1 = {r1, b1, ld1, st1, sbe1, inv1, ls1, rce1, ri1, fr1, dn1};
  localparam logic [14:0] RST_VEC = 15'h4180;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int         fresh_n, st_n, inv_n, rc_n, lin_n, busy_n, first_busy, last_busy;
  int         d1_n, d1_first;
  logic [47:0] rc_seq;
  logic [21:0] lin_seq;
  int         done_q[$];

  initial begin
    i_rst = 1'b1; i_start = 1'b0; i_abort = 1'b0;
    tick(); tick();
    chk("rst_vec", 64'(v0), 64'(RST_VEC));
    chk("rst_vec_lat1", 64'(v1), 64'(RST_VEC));
    i_rst = 1'b0;
    tick();
    chk("idle_vec", 64'(v0), 64'(RST_VEC));

    // Run 1: start at t0, stray start at t0+10, back-to-back start at t0+39.
    fresh_n = 0; st_n = 0; inv_n = 0; rc_n = 0; lin_n = 0; busy_n = 0;
    first_busy = -1; last_busy = -1; d1_n = 0; d1_first = -1;
    rc_seq = '0; lin_seq = '0;
    chk("ready_t0", 64'(r0), 64'd1);
    i_start = 1'b1;
    for (int k = 1; k <= 80; k++) begin
      tick();
      i_start = (k == 10) || (k == 39);
      if (k == 1)  chk("ld_en_t1", 64'(ld0), 64'd1);
      if (k == 39) chk("ready_t39", 64'(r0), 64'd1);
      if (dn0) done_q.push_back(k);
      if (k <= 38) begin
        if (fr0)  fresh_n++;
        if (st0)  st_n++;
        if (inv0) inv_n++;
        if (b0) begin
          busy_n++;
          if (first_busy < 0) first_busy = k;
          last_busy = k;
        end
        if (rce0) begin
          rc_seq = {rc_seq[43:0], ri0};
          rc_n++;
        end
        if (ls0 != 2'd3) begin
          lin_seq = {lin_seq[19:0], ls0};
          lin_n++;
        end
        if (dn1) begin
          d1_n++;
          if (d1_first < 0) d1_first = k;
        end
      end
    end
    chk("rc_seq", 64'(rc_seq), 64'h0123456789AB);
    chk("rc_count", 64'(rc_n), 64'd12);
    chk("lin_seq", 64'(lin_seq), 64'h6AA);
    chk("lin_count", 64'(lin_n), 64'd11);
    chk("sb_inv_count", 64'(inv_n), 64'd12);
    chk("fresh_count", 64'(fresh_n), 64'd24);
    chk("st_en_count", 64'(st_n), 64'd25);
    chk("busy_count", 64'(busy_n), 64'd37);
    chk("busy_first", 64'(first_busy), 64'd1);
    chk("busy_last", 64'(last_busy), 64'd37);
    chk("done_pulses", 64'(done_q.size()), 64'd2);
    if (done_q.size() == 2) begin
      chk("done_t38", 64'(done_q[0]), 64'd38);
      chk("done_t77", 64'(done_q[1]), 64'd77);
    end
    chk("lat1_done_count", 64'(d1_n), 64'd1);
    chk("lat1_done_t26", 64'(d1_first), 64'd26);

    // Run 2: abort at t0+20, then start together with abort while idle at t0+22.
    done_q.delete();
    i_start = 1'b1;
    for (int k = 1; k <= 64; k++) begin
      tick();
      i_start = (k == 22);
      i_abort = (k == 20) || (k == 22);
      if (k == 20) chk("busy_before_abort", 64'(b0), 64'd1);
      if (k == 21) chk("abort_idle_vec", 64'(v0), 64'(RST_VEC));
      if (k == 23) chk("restart_ld_t23", 64'(ld0), 64'd1);
      if (dn0) done_q.push_back(k);
    end
    i_abort = 1'b0;
    chk("abort_done_pulses", 64'(done_q.size()), 64'd1);
    if (done_q.size() == 1) chk("restart_done_t60", 64'(done_q[0]), 64'd60);

    // Run 3: synchronous reset at t0+15 mid-run.
    done_q.delete();
    i_start = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      tick();
      i_start = 1'b0;
      i_rst = (k == 15);
      if (k == 15) chk("busy_before_rst", 64'(b0), 64'd1);
      if (k == 16) begin
        chk("mid_rst_vec", 64'(v0), 64'(RST_VEC));
        chk("mid_rst_vec_lat1", 64'(v1), 64'(RST_VEC));
      end
      if (k == 17) chk("post_rst_idle", 64'(v0), 64'(RST_VEC));
      if (dn0) done_q.push_back(k);
    end
    chk("rst_no_done", 64'(done_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
